// File: rtl/seq_taillight_ctrl.sv
// seq_taillight_ctrl
//   Sequential tail-light controller with N_LAMPS lamps per side. A turn on
//   one side runs a growing pattern from the inside out. With the brake held,
//   that side runs the inverted (shrinking) pattern instead. The other side,
//   and both sides when idle or when both turns are requested, show the steady
//   brake state. Every output is registered, so no input reaches an output
//   without passing through a flop.
//
//   Optional feature: define TAIL_HAZARD_EN to enable the hazard flasher.
//   Without it, the hazard input is accepted but ignored, and no hazard
//   counter is built.
//
// Parameters
//   N_LAMPS      lamps per side (>= 1)
//   STEP_CYCLES  clock cycles each sequence step is held (>= 1)
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   turn_left    left turn request (level)
//   turn_right   right turn request (level)
//   brake        brake pedal (level)
//   hazard       hazard switch (level)
//   left_lamps   left lamp enables, bit 0 innermost
//   right_lamps  right lamp enables, bit 0 innermost

module seq_taillight_ctrl #(
    parameter int unsigned N_LAMPS     = 3,
    parameter int unsigned STEP_CYCLES = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               turn_left,
    input  logic               turn_right,
    input  logic               brake,
    input  logic               hazard,
    output logic [N_LAMPS-1:0] left_lamps,
    output logic [N_LAMPS-1:0] right_lamps
);

    localparam int unsigned CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam int unsigned SW = ($clog2(N_LAMPS + 1) > 0) ? $clog2(N_LAMPS + 1) : 1;

    localparam logic [CW-1:0] CNT_MAX = CW'(STEP_CYCLES - 1);
    localparam logic [SW-1:0] S_MAX   = SW'(N_LAMPS);

    typedef enum logic [2:0] {
        ModeIdle,
        ModeConflict,
        ModeLeft,
        ModeRight,
        ModeHazard
    } mode_e;

    mode_e mode;

    logic [CW-1:0] cnt_l_q, cnt_l_d, cnt_l_run;
    logic [SW-1:0] s_l_q, s_l_d, s_l_run;
    logic [CW-1:0] cnt_r_q, cnt_r_d, cnt_r_run;
    logic [SW-1:0] s_r_q, s_r_d, s_r_run;
    logic [N_LAMPS-1:0] left_d, right_d, fill;

`ifdef TAIL_HAZARD_EN
    logic [CW-1:0] hz_cnt_q, hz_cnt_d;
    // 0 = ON phase, so the cleared state is the ON phase on hazard entry
    logic          hz_phase_q, hz_phase_d;
`else
    logic unused_hazard;
    assign unused_hazard = hazard;
`endif

    // Growing thermometer without brake; all-ones shifted left by s with brake.
    // Step N_LAMPS is the dark step in both mappings.
    function automatic logic [N_LAMPS-1:0] seq_pattern(input logic [SW-1:0] s,
                                                      input logic          brk);
        logic [N_LAMPS-1:0] p;
        p = '0;
        for (int i = 0; i < int'(N_LAMPS); i++) begin
            if (brk) p[i] = (i >= int'(s));
            else     p[i] = (i <= int'(s)) && (int'(s) < int'(N_LAMPS));
        end
        return p;
    endfunction

    // Mode priority: hazard > conflict > single turn > idle
    always_comb begin
        mode = ModeIdle;
        if (turn_left && turn_right) mode = ModeConflict;
        else if (turn_left)          mode = ModeLeft;
        else if (turn_right)         mode = ModeRight;
`ifdef TAIL_HAZARD_EN
        if (hazard) mode = ModeHazard;
`endif
    end

    // Free-running advance values, used only when a side is active
    always_comb begin
        cnt_l_run = cnt_l_q + CW'(1);
        s_l_run   = s_l_q;
        if (cnt_l_q == CNT_MAX) begin
            cnt_l_run = '0;
            s_l_run   = (s_l_q == S_MAX) ? '0 : s_l_q + SW'(1);
        end
        cnt_r_run = cnt_r_q + CW'(1);
        s_r_run   = s_r_q;
        if (cnt_r_q == CNT_MAX) begin
            cnt_r_run = '0;
            s_r_run   = (s_r_q == S_MAX) ? '0 : s_r_q + SW'(1);
        end
    end

    always_comb begin
        cnt_l_d = '0;
        s_l_d   = '0;
        cnt_r_d = '0;
        s_r_d   = '0;
`ifdef TAIL_HAZARD_EN
        hz_cnt_d   = '0;
        hz_phase_d = 1'b0;
`endif
        fill    = {N_LAMPS{brake}};
        left_d  = fill;
        right_d = fill;
        unique case (mode)
            ModeHazard: begin
`ifdef TAIL_HAZARD_EN
                left_d  = {N_LAMPS{brake || !hz_phase_q}};
                right_d = {N_LAMPS{brake || !hz_phase_q}};
                if (hz_cnt_q == CNT_MAX) begin
                    hz_cnt_d   = '0;
                    hz_phase_d = ~hz_phase_q;
                end else begin
                    hz_cnt_d   = hz_cnt_q + CW'(1);
                    hz_phase_d = hz_phase_q;
                end
`endif
            end
            ModeLeft: begin
                left_d  = seq_pattern(s_l_q, brake);
                cnt_l_d = cnt_l_run;
                s_l_d   = s_l_run;
            end
            ModeRight: begin
                right_d = seq_pattern(s_r_q, brake);
                cnt_r_d = cnt_r_run;
                s_r_d   = s_r_run;
            end
            ModeConflict, ModeIdle: ;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_l_q     <= '0;
            s_l_q       <= '0;
            cnt_r_q     <= '0;
            s_r_q       <= '0;
            left_lamps  <= '0;
            right_lamps <= '0;
`ifdef TAIL_HAZARD_EN
            hz_cnt_q    <= '0;
            hz_phase_q  <= 1'b0;
`endif
        end else begin
            cnt_l_q     <= cnt_l_d;
            s_l_q       <= s_l_d;
            cnt_r_q     <= cnt_r_d;
            s_r_q       <= s_r_d;
            left_lamps  <= left_d;
            right_lamps <= right_d;
`ifdef TAIL_HAZARD_EN
            hz_cnt_q    <= hz_cnt_d;
            hz_phase_q  <= hz_phase_d;
`endif
        end
    end

endmodule

// File: tb/tb_seq_taillight_ctrl.sv
// Directed bench for seq_taillight_ctrl with N_LAMPS=3, STEP_CYCLES=5.
// Inputs change 1 ns after a rising edge; outputs are checked at the same point.

module tb_seq_taillight_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       turn_left = 1'b0;
    logic       turn_right = 1'b0;
    logic       brake = 1'b0;
    logic       hazard = 1'b0;
    logic [2:0] left_lamps;
    logic [2:0] right_lamps;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    seq_taillight_ctrl #(
        .N_LAMPS    (3),
        .STEP_CYCLES(5)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .turn_left  (turn_left),
        .turn_right (turn_right),
        .brake      (brake),
        .hazard     (hazard),
        .left_lamps (left_lamps),
        .right_lamps(right_lamps)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (left_lamps !== 3'b000)
            $display("FAIL reset_left: got %b want 000", left_lamps);
        else passed++;
        checks++;
        if (right_lamps !== 3'b000)
            $display("FAIL reset_right: got %b want 000", right_lamps);
        else passed++;
        rst_n = 1'b1;
        tick();
        checks++;
        if (left_lamps !== 3'b000 || right_lamps !== 3'b000)
            $display("FAIL idle: got %b/%b want 000/000", left_lamps, right_lamps);
        else passed++;
    endtask

    task automatic test_turn_left();
        logic [2:0] exp [4];
        exp = '{3'b001, 3'b011, 3'b111, 3'b000};
        turn_left = 1'b1;
        for (int k = 0; k < 25; k++) begin
            tick();
            checks++;
            if (left_lamps !== exp[(k / 5) % 4] || right_lamps !== 3'b000)
                $display("FAIL turn_left cycle %0d: got %b/%b want %b/000",
                         k + 1, left_lamps, right_lamps, exp[(k / 5) % 4]);
            else passed++;
        end
        turn_left = 1'b0;
        tick();
        checks++;
        if (left_lamps !== 3'b000)
            $display("FAIL turn_left_release: got %b want 000", left_lamps);
        else passed++;
    endtask

    task automatic test_turn_right_brake();
        logic [2:0] exp [4];
        exp = '{3'b111, 3'b110, 3'b100, 3'b000};
        turn_right = 1'b1;
        brake = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            checks++;
            if (right_lamps !== exp[k / 5] || left_lamps !== 3'b111)
                $display("FAIL turn_right_brake cycle %0d: got L%b R%b want L111 R%b",
                         k + 1, left_lamps, right_lamps, exp[k / 5]);
            else passed++;
        end
        turn_right = 1'b0;
        brake = 1'b0;
        tick();
    endtask

    task automatic test_direction_change();
        turn_left = 1'b1;
        for (int k = 0; k < 7; k++) tick();
        checks++;
        if (left_lamps !== 3'b011)
            $display("FAIL dir_pre: got %b want 011", left_lamps);
        else passed++;
        turn_left = 1'b0;
        turn_right = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            checks++;
            if (k < 5 && (left_lamps !== 3'b000 || right_lamps !== 3'b001))
                $display("FAIL dir_change cycle %0d: got L%b R%b want L000 R001",
                         k + 1, left_lamps, right_lamps);
            else if (k == 5 && right_lamps !== 3'b011)
                $display("FAIL dir_change step1: got %b want 011", right_lamps);
            else passed++;
        end
        turn_left = 1'b1;
        tick();
        checks++;
        if (left_lamps !== 3'b000 || right_lamps !== 3'b000)
            $display("FAIL conflict: got %b/%b want 000/000", left_lamps, right_lamps);
        else passed++;
        brake = 1'b1;
        tick();
        checks++;
        if (left_lamps !== 3'b111 || right_lamps !== 3'b111)
            $display("FAIL conflict_brake: got %b/%b want 111/111", left_lamps, right_lamps);
        else passed++;
        // Conflict must have cleared the right sequencer: right alone restarts at step 0
        turn_left = 1'b0;
        brake = 1'b0;
        tick();
        checks++;
        if (right_lamps !== 3'b001)
            $display("FAIL conflict_clear: got %b want 001", right_lamps);
        else passed++;
        turn_right = 1'b0;
        tick();
    endtask

    task automatic test_brake_mid();
        logic [2:0] exp [5];
        exp = '{3'b110, 3'b110, 3'b110, 3'b100, 3'b100};
        turn_left = 1'b1;
        for (int k = 0; k < 7; k++) tick();
        brake = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if (left_lamps !== exp[k] || right_lamps !== 3'b111)
                $display("FAIL brake_mid cycle %0d: got L%b R%b want L%b R111",
                         k + 8, left_lamps, right_lamps, exp[k]);
            else passed++;
        end
        turn_left = 1'b0;
        brake = 1'b0;
        tick();
    endtask

    task automatic test_hazard();
        logic [2:0] e;
        hazard = 1'b1;
        for (int k = 0; k < 25; k++) begin
            tick();
`ifdef TAIL_HAZARD_EN
            e = ((k / 5) % 2 == 0) ? 3'b111 : 3'b000;
`else
            e = 3'b000;
`endif
            checks++;
            if (left_lamps !== e || right_lamps !== e)
                $display("FAIL hazard cycle %0d: got %b/%b want %b/%b",
                         k + 1, left_lamps, right_lamps, e, e);
            else passed++;
        end
        // Cycle 26 falls in an OFF phase
        brake = 1'b1;
        tick();
        checks++;
        if (left_lamps !== 3'b111 || right_lamps !== 3'b111)
            $display("FAIL hazard_brake: got %b/%b want 111/111", left_lamps, right_lamps);
        else passed++;
        brake = 1'b0;
        tick();
        checks++;
        if (left_lamps !== 3'b000 || right_lamps !== 3'b000)
            $display("FAIL hazard_off_after_brake: got %b/%b want 000/000",
                     left_lamps, right_lamps);
        else passed++;
        // Hazard with a turn request still ignores the turn when enabled
        turn_left = 1'b1;
        tick();
`ifdef TAIL_HAZARD_EN
        e = 3'b000;
`else
        e = 3'b001;
`endif
        checks++;
        if (left_lamps !== e)
            $display("FAIL hazard_over_turn: got %b want %b", left_lamps, e);
        else passed++;
        turn_left = 1'b0;
        hazard = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        turn_left = 1'b1;
        for (int k = 0; k < 7; k++) tick();
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (left_lamps !== 3'b000 || right_lamps !== 3'b000)
            $display("FAIL reset_mid: got %b/%b want 000/000", left_lamps, right_lamps);
        else passed++;
        #2;
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            checks++;
            if (left_lamps !== ((k < 5) ? 3'b001 : 3'b011))
                $display("FAIL reset_restart cycle %0d: got %b want %b",
                         k + 1, left_lamps, (k < 5) ? 3'b001 : 3'b011);
            else passed++;
        end
        turn_left = 1'b0;
        tick();
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_turn_left();
        test_turn_right_brake();
        test_direction_change();
        test_brake_mid();
        test_hazard();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
